// File: rtl/d_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package d_mem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_DMA  = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        port_onehot = NUM_PORTS'(1) << port;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the port that did not win last time takes a tie.
module rr_pick2
    import d_mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic                 last_grant,
    output logic                 valid,
    output logic                 winner
);

    always_comb begin
        valid  = |eligible;
        winner = 1'(PORT_CPU);
        if (&eligible) begin
            winner = (last_grant == 1'(PORT_CPU)) ? 1'(PORT_DMA) : 1'(PORT_CPU);
        end else if (eligible[PORT_DMA]) begin
            winner = 1'(PORT_DMA);
        end
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between CPU and DMA.
// Optional address bounds check enabled with `define D_MEM_BOUNDS_CHECK_EN.
module d_mem_arbiter
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEMORY_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] we,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DATA_W-1:0]    wdata0,
    input  logic [DATA_W-1:0]    wdata1,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [NUM_PORTS-1:0] rvalid,
    output logic [DATA_W-1:0]    rdata,
    output logic [NUM_PORTS-1:0] err,
    output logic [ADDR_W-1:0]    memAddress,
    output logic [DATA_W-1:0]    writeData,
    output logic                 memWrite,
    output logic                 memRead,
    input  logic [DATA_W-1:0]    readData
);

    // Reject a zero-sized memory at elaboration.
    if (MEMORY_SIZE == 0) begin : g_bad_size
        $error("d_mem_arbiter: MEMORY_SIZE must be nonzero");
    end

    state_t                r_state, w_state_nxt;
    logic                  r_last_grant, w_last_nxt;
    logic                  r_port, w_port_nxt;
    logic [NUM_PORTS-1:0]  r_gnt, w_gnt_nxt;
    logic [NUM_PORTS-1:0]  r_rvalid, w_rvalid_nxt;
    logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;
    logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_wdata, w_wdata_nxt;
    logic                  r_mem_write, w_mem_write_nxt;
    logic                  r_mem_read, w_mem_read_nxt;
`ifdef D_MEM_BOUNDS_CHECK_EN
    logic                  r_oob, w_oob_nxt;
    logic [NUM_PORTS-1:0]  r_err, w_err_nxt;
`endif

    logic [NUM_PORTS-1:0]  w_eligible;
    logic                  w_valid;
    logic                  w_winner;
    logic                  w_win_we;
    logic [ADDR_W-1:0]     w_win_addr;
    logic [DATA_W-1:0]     w_win_wdata;

    // The port in its SERVE cycle still holds req at this edge, so mask it out.
    assign w_eligible  = req & ~r_gnt;
    assign w_win_we    = w_winner ? we[PORT_DMA] : we[PORT_CPU];
    assign w_win_addr  = w_winner ? addr1 : addr0;
    assign w_win_wdata = w_winner ? wdata1 : wdata0;

    rr_pick2 u_pick (
        .eligible   (w_eligible),
        .last_grant (r_last_grant),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last_grant;
        w_port_nxt      = r_port;
        w_gnt_nxt       = '0;
        w_rvalid_nxt    = '0;
        w_rdata_nxt     = r_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_wdata_nxt     = r_wdata;
        w_mem_write_nxt = 1'b0;
        w_mem_read_nxt  = 1'b0;
`ifdef D_MEM_BOUNDS_CHECK_EN
        w_oob_nxt       = 1'b0;
        w_err_nxt       = '0;
`endif

        case (r_state)
            IDLE: begin
            end
            SERVE: begin
                if (r_mem_read) begin
                    w_rdata_nxt  = readData;
                    w_rvalid_nxt = port_onehot(r_port);
                end
`ifdef D_MEM_BOUNDS_CHECK_EN
                if (r_oob) begin
                    w_err_nxt = port_onehot(r_port);
                end
`endif
            end
            default: begin
            end
        endcase

        if (w_valid) begin
            w_state_nxt    = SERVE;
            w_last_nxt     = w_winner;
            w_port_nxt     = w_winner;
            w_gnt_nxt      = port_onehot(w_winner);
            w_mem_addr_nxt = w_win_addr;
            w_wdata_nxt    = w_win_wdata;
`ifdef D_MEM_BOUNDS_CHECK_EN
            w_oob_nxt       = (w_win_addr >= ADDR_W'(MEMORY_SIZE));
            w_mem_write_nxt = w_win_we & ~w_oob_nxt;
            w_mem_read_nxt  = ~w_win_we & ~w_oob_nxt;
`else
            w_mem_write_nxt = w_win_we;
            w_mem_read_nxt  = ~w_win_we;
`endif
        end else begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'(PORT_DMA);
            r_port       <= 1'(PORT_CPU);
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_wdata      <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
`ifdef D_MEM_BOUNDS_CHECK_EN
            r_oob        <= 1'b0;
            r_err        <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_port       <= w_port_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rvalid     <= w_rvalid_nxt;
            r_rdata      <= w_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_read   <= w_mem_read_nxt;
`ifdef D_MEM_BOUNDS_CHECK_EN
            r_oob        <= w_oob_nxt;
            r_err        <= w_err_nxt;
`endif
        end
    end

    // Strobes are gated by reset so a write in flight at a reset edge is dropped.
    assign memWrite   = r_mem_write & ~reset;
    assign memRead    = r_mem_read & ~reset;
    assign memAddress = r_mem_addr;
    assign writeData  = r_wdata;
    assign gnt        = r_gnt;
    assign rvalid     = r_rvalid;
    assign rdata      = r_rdata;
`ifdef D_MEM_BOUNDS_CHECK_EN
    assign err        = r_err;
`else
    assign err        = '0;
`endif

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Scoreboard bench for d_mem_arbiter with a behavioural 64-word data memory.
module tb_d_mem_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MEM_WORDS = 64;

    logic              clk;
    logic              reset;
    logic [1:0]        req, we;
    logic              req0_d, req1_d, we0_d, we1_d;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        gnt, rvalid, err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] writeData;
    logic              memWrite, memRead;
    logic [DATA_W-1:0] readData;

    assign req = {req1_d, req0_d};
    assign we  = {we1_d, we0_d};

    d_mem_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEMORY_SIZE (MEM_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .err        (err),
        .memAddress (memAddress),
        .writeData  (writeData),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .readData   (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic              mem_clear;
    assign readData = (memRead && memAddress < ADDR_W'(MEM_WORDS)) ? mem[memAddress[5:0]] : '0;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
        end else if (memWrite && memAddress < ADDR_W'(MEM_WORDS)) begin
            mem[memAddress[5:0]] <= writeData;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DATA_W-1:0] exp_mem [MEM_WORDS];
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    int glog_cyc[$];
    int glog_port[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pop expected read data on every rvalid, log grants.
    always @(negedge clk) begin
        if (!reset) begin
            if (rvalid[0]) begin
                if (exp_q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
                else check("rdata_p0", rdata, exp_q0.pop_front());
            end
            if (rvalid[1]) begin
                if (exp_q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
                else check("rdata_p1", rdata, exp_q1.pop_front());
            end
            if (gnt != 2'b00) begin
                glog_cyc.push_back(cyc);
                glog_port.push_back(gnt[1] ? 1 : 0);
            end
        end
    end

    // One access on port p: hold until gnt is seen at an edge, then release.
    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        logic [5:0] idx;
        idx = a[5:0];
        if (p == 0) begin
            req0_d = 1'b1; we0_d = w; addr0 = a; wdata0 = d;
        end else begin
            req1_d = 1'b1; we1_d = w; addr1 = a; wdata1 = d;
        end
        if (w) exp_mem[idx] = d;
        else if (p == 0) exp_q0.push_back(exp_mem[idx]);
        else exp_q1.push_back(exp_mem[idx]);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (gnt[p] !== 1'b1 && n < 64);
        check($sformatf("gnt%0d_seen", p), 32'(gnt[p]), 32'd1);
        @(posedge clk); #1;
        if (p == 0) req0_d = 1'b0;
        else req1_d = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_clear = 1'b1;
        req0_d = 0; req1_d = 0; we0_d = 0; we1_d = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) exp_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_memaddr", memAddress, 32'd0);
        check("rst_wdata", writeData, 32'd0);
        check("rst_memwrite", 32'(memWrite), 32'd0);
        check("rst_memread", 32'(memRead), 32'd0);
        reset = 1'b0; mem_clear = 1'b0;
        @(posedge clk); #1;

        // Port 0 write then read of addr 5
        req0_d = 1'b1; we0_d = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("wr_gnt", 32'(gnt), 32'd1);
        check("wr_memwrite", 32'(memWrite), 32'd1);
        check("wr_memread", 32'(memRead), 32'd0);
        check("wr_memaddr", memAddress, 32'd5);
        check("wr_wdata", writeData, 32'hDEADBEEF);
        @(posedge clk); #1;
        exp_mem[5] = 32'hDEADBEEF;
        check("wr_gnt_drop", 32'(gnt), 32'd0);
        check("wr_memwrite_drop", 32'(memWrite), 32'd0);
        check("wr_mem5", mem[5], exp_mem[5]);
        check("wr_no_rvalid", 32'(rvalid), 32'd0);
        we0_d = 1'b0;
        exp_q0.push_back(exp_mem[5]);
        @(posedge clk); #1;
        check("rd_gnt", 32'(gnt), 32'd1);
        check("rd_memread", 32'(memRead), 32'd1);
        check("rd_rvalid_early", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        req0_d = 1'b0;
        check("rd_rvalid", 32'(rvalid), 32'd1);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("rd_rvalid_pulse", 32'(rvalid), 32'd0);
        check("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // Port 1 streaming writes to 10..13
        glog_cyc.delete(); glog_port.delete();
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'(10 + i), 32'hA000_0000 + 32'(i));
        check("stream_count", 32'(glog_port.size()), 32'd4);
        for (int i = 0; i < glog_port.size() && i < 4; i++) begin
            check($sformatf("stream_port%0d", i), 32'(glog_port[i]), 32'd1);
            check($sformatf("stream_gap%0d", i), 32'(glog_cyc[i] - glog_cyc[0]), 32'(2 * i));
        end
        for (int i = 10; i < 14; i++) check($sformatf("stream_mem%0d", i), mem[i], exp_mem[i]);

        // Contention: both ports read every cycle
        issue(1, 1'b1, 32'd1, 32'h11);
        issue(1, 1'b1, 32'd2, 32'h22);
        @(posedge clk); #1;
        glog_cyc.delete(); glog_port.delete();
        fork
            for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'd1, 32'h0);
            for (int j = 0; j < 4; j++) issue(1, 1'b0, 32'd2, 32'h0);
        join
        repeat (3) @(posedge clk); #1;
        check("cont_count", 32'(glog_port.size()), 32'd8);
        for (int i = 0; i < glog_port.size() && i < 8; i++) begin
            check($sformatf("cont_port%0d", i), 32'(glog_port[i]), 32'(i % 2));
            check($sformatf("cont_cyc%0d", i), 32'(glog_cyc[i] - glog_cyc[0]), 32'(i));
        end

        // Reset in the SERVE cycle of a port 0 write to addr 7
        req0_d = 1'b1; we0_d = 1'b1; addr0 = 32'd7; wdata0 = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rstw_gnt", 32'(gnt), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        req0_d = 1'b0; reset = 1'b0;
        check("rstw_mem7", mem[7], exp_mem[7]);
        check("rstw_gnt_clr", 32'(gnt), 32'd0);
        check("rstw_rvalid_clr", 32'(rvalid), 32'd0);
        check("rstw_memwrite_clr", 32'(memWrite), 32'd0);
        @(posedge clk); #1;
        glog_cyc.delete(); glog_port.delete();
        fork
            issue(0, 1'b0, 32'd1, 32'h0);
            issue(1, 1'b0, 32'd2, 32'h0);
        join
        repeat (3) @(posedge clk); #1;
        check("rst_tie_count", 32'(glog_port.size()), 32'd2);
        if (glog_port.size() > 0) check("rst_tie_first", 32'(glog_port[0]), 32'd0);

        // Last valid word works normally
        issue(1, 1'b1, 32'd63, 32'h6363_6363);
        issue(0, 1'b0, 32'd63, 32'h0);
        repeat (3) @(posedge clk); #1;
        check("mem63", mem[63], 32'h6363_6363);

`ifdef D_MEM_BOUNDS_CHECK_EN
        // Out-of-range read is granted but never reaches memory
        req0_d = 1'b1; we0_d = 1'b0; addr0 = 32'd64;
        @(posedge clk); #1;
        check("oob_gnt", 32'(gnt), 32'd1);
        check("oob_memread", 32'(memRead), 32'd0);
        check("oob_memwrite", 32'(memWrite), 32'd0);
        @(posedge clk); #1;
        req0_d = 1'b0;
        check("oob_err", 32'(err), 32'd1);
        check("oob_no_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        check("oob_err_pulse", 32'(err), 32'd0);
`endif

        repeat (4) @(posedge clk); #1;
        check("pending_rd0", 32'(exp_q0.size()), 32'd0);
        check("pending_rd1", 32'(exp_q1.size()), 32'd0);
        check("final_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
